// File: rtl/ofs_avmm_csr_pkg.sv
// Shared types and constants for the AVMM CSR responder.
// Build option: OFS_AVMM_CSR_WRRESP_EN enables writeresponsevalid.
package ofs_avmm_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_BURST
    } t_rsp_state;

    // Returned for any word index beyond the implemented register file.
    localparam logic [63:0] OOR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] DEFAULT_ID  = 64'h0F50_A33A_0001_0000;

    // Byte address to word index: drop the byte-lane bits.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned lsb);
        return byte_addr >> lsb;
    endfunction

endpackage

// File: rtl/ofs_avmm_csr_if.sv
// AVMM link between a source (master) and the CSR responder (slave).
// Build option: OFS_AVMM_CSR_WRRESP_EN enables writeresponsevalid.
interface ofs_avmm_csr_if #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 16,
    parameter int BURST_W = 4
);
    localparam int BE_W = DATA_W / 8;

    logic                write;
    logic                read;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   writedata;
    logic [BURST_W-1:0]  burstcount;
    logic [BE_W-1:0]     byteenable;
    logic                waitrequest;
    logic                readdatavalid;
    logic [DATA_W-1:0]   readdata;
    logic                writeresponsevalid;

    modport master (
        output write, read, address, writedata, burstcount, byteenable,
        input  waitrequest, readdatavalid, readdata, writeresponsevalid
    );

    modport slave (
        input  write, read, address, writedata, burstcount, byteenable,
        output waitrequest, readdatavalid, readdata, writeresponsevalid
    );

endinterface

// File: rtl/ofs_avmm_csr_regfile.sv
// Byte-enabled register array: one write port, one combinational read port.
// Build option: OFS_AVMM_CSR_WRRESP_EN (not used in this file).
module ofs_avmm_csr_regfile #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 16,
    localparam int BE_W    = DATA_W / 8,
    localparam int RIDX_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   wbe,
    input  logic [RIDX_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // NOTE: the array is flops, not a RAM macro, so a whole-array synchronous clear is legal here.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ofs_avmm_csr_responder.sv
// AVMM sink serving single/burst reads and writes to a 64-bit CSR file.
// Build option: OFS_AVMM_CSR_WRRESP_EN enables writeresponsevalid pulses.
module ofs_avmm_csr_responder
    import ofs_avmm_csr_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter int          ADDR_W   = 16,
    parameter int          BURST_W  = 4,
    parameter int          NUM_REGS = 16,
    parameter logic [63:0] ID_VALUE = DEFAULT_ID
) (
    input  logic               clk,
    input  logic               rst,
    ofs_avmm_csr_if.slave      avmm
);

    localparam int BE_W     = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(BE_W);
    localparam int IDX_W    = ADDR_W - ADDR_LSB;
    localparam int RIDX_W   = $clog2(NUM_REGS);

    t_rsp_state         state;
    logic [IDX_W-1:0]   ptr;
    logic [BURST_W-1:0] beats_left;

    logic [IDX_W-1:0]   addr_idx;
    logic [IDX_W-1:0]   acc_idx;
    logic [BURST_W-1:0] eff_bc;
    logic               wr_accept;
    logic               rd_accept;
    logic               wr_fire;
    logic               reg_we;
    logic [DATA_W-1:0]  rf_rdata;
    logic [DATA_W-1:0]  rd_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        addr_idx  = IDX_W'(word_index(32'(avmm.address), ADDR_LSB));
        eff_bc    = (avmm.burstcount == '0) ? BURST_W'(1) : avmm.burstcount;
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        acc_idx   = ptr;
        if (state == ST_IDLE) begin
            acc_idx   = addr_idx;
            // Write wins when a misbehaving source raises both strobes.
            wr_accept = avmm.write && !avmm.waitrequest;
            rd_accept = avmm.read && !avmm.write && !avmm.waitrequest;
        end
        wr_fire = wr_accept || (state == ST_WR_BURST && avmm.write);
        reg_we  = wr_fire && (acc_idx != '0) && (acc_idx < IDX_W'(NUM_REGS));

        rd_data = rf_rdata;
        if (acc_idx == '0)
            rd_data = DATA_W'(ID_VALUE);
        else if (acc_idx >= IDX_W'(NUM_REGS))
            rd_data = DATA_W'(OOR_PATTERN);
    end

    ofs_avmm_csr_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (reg_we),
        .waddr (acc_idx[RIDX_W-1:0]),
        .wdata (avmm.writedata),
        .wbe   (avmm.byteenable),
        .raddr (acc_idx[RIDX_W-1:0]),
        .rdata (rf_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            ptr                <= '0;
            beats_left         <= '0;
            avmm.waitrequest   <= 1'b1;
            avmm.readdatavalid <= 1'b0;
            avmm.readdata      <= '0;
        end else begin
            avmm.readdatavalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    avmm.waitrequest <= 1'b0;
                    if (wr_accept) begin
                        ptr        <= addr_idx + 1'b1;
                        beats_left <= eff_bc - 1'b1;
                        if (eff_bc != BURST_W'(1)) state <= ST_WR_BURST;
                    end else if (rd_accept) begin
                        state              <= ST_RD_BURST;
                        avmm.waitrequest   <= 1'b1;
                        avmm.readdatavalid <= 1'b1;
                        avmm.readdata      <= rd_data;
                        ptr                <= addr_idx + 1'b1;
                        beats_left         <= eff_bc - 1'b1;
                    end
                end
                ST_WR_BURST: begin
                    // A low write strobe is a bubble; the burst simply waits.
                    if (avmm.write) begin
                        ptr        <= ptr + 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == BURST_W'(1)) state <= ST_IDLE;
                    end
                end
                ST_RD_BURST: begin
                    if (beats_left == '0) begin
                        state            <= ST_IDLE;
                        avmm.waitrequest <= 1'b0;
                    end else begin
                        avmm.readdatavalid <= 1'b1;
                        avmm.readdata      <= rd_data;
                        ptr                <= ptr + 1'b1;
                        beats_left         <= beats_left - 1'b1;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    avmm.waitrequest <= 1'b0;
                end
            endcase
        end
    end

`ifdef OFS_AVMM_CSR_WRRESP_EN
    logic wr_last;

    always_comb begin
        wr_last = 1'b0;
        if (wr_accept)
            wr_last = (eff_bc == BURST_W'(1));
        else if (state == ST_WR_BURST && avmm.write)
            wr_last = (beats_left == BURST_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) avmm.writeresponsevalid <= 1'b0;
        else     avmm.writeresponsevalid <= wr_last;
    end
`else
    assign avmm.writeresponsevalid = 1'b0;
`endif

endmodule

// File: tb/tb_ofs_avmm_csr_responder.sv
// Self-checking bench for ofs_avmm_csr_responder against a word-array reference model.
// Build option: OFS_AVMM_CSR_WRRESP_EN selects whether write responses are expected.
module tb_ofs_avmm_csr_responder;

    localparam logic [63:0] ID_EXP  = 64'h0F50_A33A_0001_0000;
    localparam logic [63:0] OOR_EXP = 64'hDEAD_BEEF_DEAD_BEEF;
`ifdef OFS_AVMM_CSR_WRRESP_EN
    localparam logic WRV_EN = 1'b1;
`else
    localparam logic WRV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ofs_avmm_csr_if bus ();

    ofs_avmm_csr_responder dut (
        .clk  (clk),
        .rst  (rst),
        .avmm (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain array of the 16 implemented words.
    logic [63:0] mregs [16];
    logic [63:0] wdat  [16];
    logic [7:0]  wbe   [16];

    function automatic logic [63:0] model_read(input int unsigned idx);
        int unsigned i = idx % 8192;
        if (i == 0)  return ID_EXP;
        if (i >= 16) return OOR_EXP;
        return mregs[i];
    endfunction

    task automatic model_write(input int unsigned idx, input logic [63:0] d, input logic [7:0] be);
        int unsigned i = idx % 8192;
        if (i != 0 && i < 16)
            for (int b = 0; b < 8; b++) if (be[b]) mregs[i][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.waitrequest !== 1'b0 && n < 32) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(bus.waitrequest), 64'd0);
    endtask

    // Write burst from wdat/wbe; bubble_at>0 inserts one idle cycle (with read raised) before that beat.
    task automatic do_write(input string tag, input logic [15:0] addr, input int bc, input int bubble_at);
        int eff = (bc == 0) ? 1 : bc;
        wait_ready(tag);
        for (int n = 0; n < eff; n++) begin
            if (n > 0 && n == bubble_at) begin
                bus.write = 1'b0;
                bus.read  = 1'b1;
                tick();
                bus.read  = 1'b0;
            end
            bus.write      = 1'b1;
            bus.address    = addr;
            bus.burstcount = 4'(bc);
            bus.writedata  = wdat[n];
            bus.byteenable = wbe[n];
            tick();
            model_write(int'(addr >> 3) + n, wdat[n], wbe[n]);
            if (n < eff - 1) check({tag, "_wrv_mid"}, 64'(bus.writeresponsevalid), 64'd0);
        end
        bus.write = 1'b0;
        check({tag, "_wrv"}, 64'(bus.writeresponsevalid), 64'(WRV_EN));
        tick();
        check({tag, "_wrv_end"}, 64'(bus.writeresponsevalid), 64'd0);
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr, input int bc);
        int eff = (bc == 0) ? 1 : bc;
        wait_ready(tag);
        bus.read       = 1'b1;
        bus.address    = addr;
        bus.burstcount = 4'(bc);
        tick();
        bus.read = 1'b0;
        for (int n = 0; n < eff; n++) begin
            check({tag, "_rdv"}, 64'(bus.readdatavalid), 64'd1);
            check({tag, "_data"}, bus.readdata, model_read(int'(addr >> 3) + n));
            check({tag, "_wait"}, 64'(bus.waitrequest), 64'd1);
            tick();
        end
        check({tag, "_rdv_end"}, 64'(bus.readdatavalid), 64'd0);
        check({tag, "_wait_end"}, 64'(bus.waitrequest), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [15:0] a;
        bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writedata = '0;
        bus.burstcount = '0; bus.byteenable = '0;
        model_clear();

        // Reset held four cycles
        rst = 1'b1;
        repeat (4) tick();
        check("rst_wait", 64'(bus.waitrequest), 64'd1);
        check("rst_rdv", 64'(bus.readdatavalid), 64'd0);
        check("rst_rdata", bus.readdata, 64'd0);
        check("rst_wrv", 64'(bus.writeresponsevalid), 64'd0);
        rst = 1'b0;
        tick();
        check("rel_wait", 64'(bus.waitrequest), 64'd0);

        // Single write with partial byte enables
        wdat[0] = 64'h1122334455667788; wbe[0] = 8'h0F;
        do_write("single_wr", 16'h0008, 1, 0);
        do_read("single_rd", 16'h0008, 1);
        check("single_const", mregs[1], 64'h0000000055667788);

        // Four-beat burst with a bubble, then burst read back
        for (int n = 0; n < 4; n++) begin
            wdat[n] = {$urandom, $urandom};
            wbe[n]  = 8'hFF;
        end
        do_write("burst_wr", 16'h0010, 4, 2);
        do_read("burst_rd", 16'h0010, 4);

        // ID register, read-only behaviour, tail of file and out-of-range
        do_read("id_rd", 16'h0000, 1);
        wdat[0] = {$urandom, $urandom}; wbe[0] = 8'hFF;
        do_write("id_wr", 16'h0000, 1, 0);
        do_read("id_rd2", 16'h0000, 1);
        wdat[0] = {$urandom, $urandom}; wbe[0] = 8'hFF;
        wdat[1] = {$urandom, $urandom}; wbe[1] = 8'hFF;
        do_write("tail_wr", 16'h0070, 2, 0);
        do_read("tail_rd", 16'h0070, 3);
        do_read("wrap_rd", 16'hFFF8, 3);

        // Read and write raised together: only the write executes
        wait_ready("rw_both");
        d = {$urandom, $urandom};
        bus.write = 1'b1; bus.read = 1'b1; bus.address = 16'h0018;
        bus.burstcount = 4'd1; bus.writedata = d; bus.byteenable = 8'hFF;
        tick();
        model_write(3, d, 8'hFF);
        bus.write = 1'b0; bus.read = 1'b0;
        check("rw_both_rdv", 64'(bus.readdatavalid), 64'd0);
        check("rw_both_wait", 64'(bus.waitrequest), 64'd0);
        check("rw_both_wrv", 64'(bus.writeresponsevalid), 64'(WRV_EN));
        tick();
        do_read("rw_both_rd", 16'h0018, 1);

        // burstcount=0 is one beat: a following single write must land at its own address
        wdat[0] = {$urandom, $urandom}; wbe[0] = 8'hFF;
        do_write("bc0_wr", 16'h0020, 0, 0);
        wdat[0] = {$urandom, $urandom}; wbe[0] = 8'hFF;
        do_write("bc0_next", 16'h0030, 1, 0);
        do_read("bc0_rd", 16'h0020, 2);
        do_read("bc0_rd1", 16'h0038, 0);

        // Write then read of the same register on the very next cycle
        wait_ready("wr2rd");
        d = {$urandom, $urandom};
        bus.write = 1'b1; bus.address = 16'h0048; bus.burstcount = 4'd1;
        bus.writedata = d; bus.byteenable = 8'hFF;
        tick();
        model_write(9, d, 8'hFF);
        bus.write = 1'b0; bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
        check("wr2rd_rdv", 64'(bus.readdatavalid), 64'd1);
        check("wr2rd_data", bus.readdata, d);
        tick();

        // Randomised bursts over the implemented and out-of-range space
        for (int it = 0; it < 8; it++) begin
            int bc = $urandom_range(0, 4);
            a = 16'({$urandom_range(0, 19), 3'($urandom)});
            for (int n = 0; n < 4; n++) begin
                wdat[n] = {$urandom, $urandom};
                wbe[n]  = 8'($urandom);
            end
            do_write("rnd_wr", a, bc, (it % 2 == 0) ? 1 : 0);
            a = 16'({$urandom_range(0, 19), 3'($urandom)});
            do_read("rnd_rd", a, $urandom_range(0, 5));
        end

        // Reset during beat 2 of a four-beat read aborts the burst
        wait_ready("rst_rd");
        bus.read = 1'b1; bus.address = 16'h0010; bus.burstcount = 4'd4;
        tick();
        bus.read = 1'b0;
        check("rst_rd_b0", 64'(bus.readdatavalid), 64'd1);
        tick();
        check("rst_rd_b1", 64'(bus.readdatavalid), 64'd1);
        tick();
        check("rst_rd_b2", bus.readdata, model_read(4));
        rst = 1'b1;
        tick();
        check("rst_rd_rdv", 64'(bus.readdatavalid), 64'd0);
        check("rst_rd_wait", 64'(bus.waitrequest), 64'd1);
        rst = 1'b0;
        model_clear();
        for (int n = 0; n < 4; n++) begin
            tick();
            check("rst_rd_quiet", 64'(bus.readdatavalid), 64'd0);
        end
        do_read("post_rst_rd", 16'h0000, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
